// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: hazard control for a 5-stage core with long-latency units.
// Provides M/W->E forwarding, load-use stalls, a per-register pending scoreboard
// for long-latency writes (RAW/WAW stalls and an outstanding-op cap) and branch flushes.
// Optional feature macro: HAZARD_STATS_EN adds the StallCnt/FlushCnt counters.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   RegWriteM/W, RD_M/W           M/W-stage writeback destinations (forwarding sources)
//   Rs1_E, Rs2_E, RD_E            E-stage sources and destination
//   ValidE, RegWriteE, MemtoRegE, LongE   E-stage instruction attributes
//   RS1_D, RS2_D, RD_D, RegWriteD, LongD  D-stage instruction attributes
//   LongDone, LongRd              long-latency completion and its destination
//   PCSrcE                        taken branch/jump in E
//   ForwardAE/BE                  10 = from M, 01 = from W, 00 = regfile
//   StallF, StallD, FlushD, FlushE   pipeline control
//   SbErr                         sticky: completion for a register that was not pending
//   StallCnt, FlushCnt            (HAZARD_STATS_EN only) saturating event counters
module hazard_scoreboard_unit #(
  parameter int NREG    = 32,
  parameter int REGW    = 5,
  parameter int MAX_OUT = 4,
  parameter int CNTW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic [REGW-1:0] RD_M,
  input  logic [REGW-1:0] RD_W,
  input  logic [REGW-1:0] Rs1_E,
  input  logic [REGW-1:0] Rs2_E,
  input  logic [REGW-1:0] RD_E,
  input  logic            ValidE,
  input  logic            RegWriteE,
  input  logic            MemtoRegE,
  input  logic            LongE,
  input  logic [REGW-1:0] RS1_D,
  input  logic [REGW-1:0] RS2_D,
  input  logic [REGW-1:0] RD_D,
  input  logic            RegWriteD,
  input  logic            LongD,
  input  logic            LongDone,
  input  logic [REGW-1:0] LongRd,
  input  logic            PCSrcE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
`ifdef HAZARD_STATS_EN
  output logic [31:0]     StallCnt,
  output logic [31:0]     FlushCnt,
`endif
  output logic            SbErr
);

  localparam logic [NREG-1:0] LP_ONE     = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] LP_MAX_OUT = CNTW'(MAX_OUT);
  localparam logic [CNTW-1:0] LP_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  // Scoreboard state
  logic [NREG-1:0] r_pending;
  logic [CNTW-1:0] r_out_cnt;
  logic            r_sb_err;

  logic            w_issue;
  logic            w_issue_ok;
  logic            w_done;
  logic            w_done_ok;
  logic            w_dec;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_pend_eff;
  logic [CNTW-1:0] w_cnt_eff;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            w_lw_stall;
  logic            w_raw;
  logic            w_waw;
  logic            w_full;
  logic            w_stall;

  // ---------------------------------------------------------------------------
  // Forwarding: M is the younger producer, so it takes priority over W.
  // ---------------------------------------------------------------------------
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs1_E)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && (RD_W != '0) && (RD_W == Rs1_E)) begin
      ForwardAE = 2'b01;
    end
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs2_E)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && (RD_W != '0) && (RD_W == Rs2_E)) begin
      ForwardBE = 2'b01;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  assign w_issue = ValidE && LongE && RegWriteE && (RD_E != '0);
  assign w_done  = LongDone && (LongRd != '0);

  // A completion only counts when its register is actually pending; a stray
  // completion is flagged through SbErr and otherwise ignored.
  assign w_done_ok  = w_done && r_pending[LongRd];
  assign w_dec      = w_done_ok && (r_out_cnt != '0);
  assign w_clr_mask = w_done_ok ? (LP_ONE << LongRd) : '0;

  // Pending view with this cycle's completion already retired: the result
  // reaches E through W forwarding on the next cycle, so no stall is needed.
  assign w_pend_eff = r_pending & ~w_clr_mask;
  assign w_cnt_eff  = w_dec ? (r_out_cnt - LP_CNT_ONE) : r_out_cnt;

  // An issue that would push the count past the cap is dropped; the full
  // stall on D normally keeps such an instruction from ever reaching E.
  assign w_issue_ok = w_issue && (w_cnt_eff < LP_MAX_OUT);
  assign w_set_mask = w_issue_ok ? (LP_ONE << RD_E) : '0;

  always_comb begin
    w_cnt_nxt = w_cnt_eff;
    if (w_issue_ok) begin
      w_cnt_nxt = w_cnt_eff + LP_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_out_cnt <= '0;
      r_sb_err  <= 1'b0;
    end else begin
      // Set after clear: a newer producer of the same register keeps it pending.
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
      r_out_cnt <= w_cnt_nxt;
      if (w_done && !r_pending[LongRd]) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  assign SbErr = r_sb_err;

  // ---------------------------------------------------------------------------
  // Stall / flush generation
  // ---------------------------------------------------------------------------
  assign w_lw_stall = MemtoRegE && (RD_E != '0) && ((RD_E == RS1_D) || (RD_E == RS2_D));
  assign w_raw      = w_pend_eff[RS1_D] || w_pend_eff[RS2_D];
  assign w_waw      = RegWriteD && w_pend_eff[RD_D];
  assign w_full     = LongD && (w_cnt_eff == LP_MAX_OUT);
  assign w_stall    = w_lw_stall || w_raw || w_waw || w_full;

  // A taken branch discards the D instruction, so holding it would be pointless.
  assign StallF = w_stall && !PCSrcE;
  assign StallD = w_stall && !PCSrcE;
  assign FlushD = PCSrcE;
  assign FlushE = w_stall || PCSrcE;

`ifdef HAZARD_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating event counters
  // ---------------------------------------------------------------------------
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallD && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (FlushD && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`endif

endmodule
